// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// Define BIN2BCD_SAT_EN to saturate bcd_out to 16'h9999 on overflow.
module bin2bcd_seq #(
    parameter int BIN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [15:0]      bcd_out,
    output logic             overflow
);

    // state  | meaning
    // IDLE   | waiting for start; outputs hold last result
    // CONV   | BIN_W shift-add-3 iterations
    // FINISH | publish result, pulse done
    typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

    localparam int          WIDE_W = 20 + BIN_W;
    localparam logic [4:0]  LAST   = 5'(BIN_W - 1);

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [19:0]        scratch_q, scratch_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [19:0]        adj;
    logic [WIDE_W-1:0]  wide;
    logic               ovf_now;

    // Per-digit +3 with no carry between digits.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < 5; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

    assign wide    = {adj, shift_q} << 1;
    assign ovf_now = (scratch_q[19:16] != 4'd0);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin_in;
                    scratch_d = 20'h0;
                    cnt_d     = 5'd0;
                    busy_d    = 1'b1;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = wide[WIDE_W-1:BIN_W];
                shift_d   = wide[BIN_W-1:0];
                cnt_d     = cnt_q + 5'd1;
                if (cnt_q == LAST)
                    state_d = FINISH;
            end
            FINISH: begin
                ovf_d = ovf_now;
`ifdef BIN2BCD_SAT_EN
                bcd_d = ovf_now ? 16'h9999 : scratch_q[15:0];
`else
                bcd_d = scratch_q[15:0];
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            scratch_q <= 20'h0;
            cnt_q     <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= 16'h0000;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed corner values plus random values
// against a decimal-arithmetic reference; follows BIN2BCD_SAT_EN if defined.
module tb_bin2bcd_seq;

    localparam int BIN_W = 16;
    localparam int LAT   = BIN_W + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] bin_in = 16'h0;
    logic        busy, done, overflow;
    logic [15:0] bcd_out;

    int total = 0;
    int bad   = 0;
    logic [15:0] last_bcd = 16'h0;
    logic        last_ovf = 1'b0;

    bin2bcd_seq #(.BIN_W(BIN_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        int w;
        w = v % 10000;
`ifdef BIN2BCD_SAT_EN
        if (v > 9999) w = 9999;
`endif
        return 16'((w / 1000) << 12 | ((w / 100) % 10) << 8 | ((w / 10) % 10) << 4 | (w % 10));
    endfunction

    // Called at the negedge after some accepted edge; n0 = edges elapsed since acceptance.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 40) begin
            check("busy_in_flight", {31'b0, busy}, 32'd1);
            check("bcd_hold", {16'b0, bcd_out}, {16'b0, last_bcd});
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic accept(input logic [15:0] v);
        @(negedge clk);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        bin_in = 16'($urandom);
    endtask

    task automatic check_result(input string tag, input int v, input int n);
        check({tag, "_latency"}, n, LAT);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
        check({tag, "_bcd"}, {16'b0, bcd_out}, {16'b0, ref_bcd(v)});
        check({tag, "_ovf"}, {31'b0, overflow}, {31'b0, (v > 9999)});
        last_bcd = ref_bcd(v);
        last_ovf = (v > 9999);
    endtask

    task automatic run_conv(input string tag, input int v);
        int n;
        accept(16'(v));
        wait_done(0, n);
        check_result(tag, v, n);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_1cyc"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int dir_vals[6] = '{0, 9, 10, 9999, 10000, 65535};

        #12;
        check("rst_bcd", {16'b0, bcd_out}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", {busy, done, overflow, bcd_out}, 32'h0);
        end

        run_conv("c1234", 1234);
        foreach (dir_vals[i]) run_conv($sformatf("dir%0d", dir_vals[i]), dir_vals[i]);
        for (int i = 0; i < 30; i++) begin
            int v;
            v = (i % 3 == 0) ? int'($urandom_range(0, 9999)) : int'($urandom_range(0, 65535));
            run_conv($sformatf("rnd%0d", i), v);
        end

        // start while busy is ignored; start in the done cycle is accepted
        accept(16'd1234);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        start  = 1'b1;
        bin_in = 16'd42;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(5, n);
        check_result("ignored", 1234, n);
        start  = 1'b1;
        bin_in = 16'd42;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(0, n);
        check_result("b2b", 42, n);

        // reset mid-conversion aborts with no done
        run_conv("c777", 777);
        accept(16'd5555);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("abort_bcd", {16'b0, bcd_out}, 32'h0);
        check("abort_flags", {29'b0, busy, done, overflow}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        last_bcd = 16'h0;
        n = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        check("abort_no_done", n, 0);
        run_conv("c77", 77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
